// File: rtl/score_digit_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : score_digit_seq_pkg
// Purpose  : Shared types and constants for the score digit sequencer:
//            fetch FSM states, glyph geometry and digit-cell pitch.
// Revision : 1.0 - initial release
// ============================================================================
package score_digit_seq_pkg;

    // Fetch sequencer states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    // Glyph geometry in font pixels
    localparam int c_GLYPH_W    = 5;
    localparam int c_GLYPH_H    = 5;
    // Horizontal distance between tens and ones cells, in font pixels
    localparam int c_CELL_PITCH = 6;

    // Nibble idx of a packed BCD score word, idx 0 = most significant
    function automatic logic [3:0] score_nibble(input logic [15:0] word,
                                                input logic [1:0]  idx);
        logic [3:0] r_nib;
        case (idx)
            2'd0:    r_nib = word[15:12];
            2'd1:    r_nib = word[11:8];
            2'd2:    r_nib = word[7:4];
            default: r_nib = word[3:0];
        endcase
        return r_nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : score_line_buf
// Purpose  : Holds one glyph row per digit cell for the line being drawn,
//            decodes hpos into cell/column and registers the score pixel.
// Revision : 1.0 - initial release
// ============================================================================
module score_line_buf
    import score_digit_seq_pkg::*;
#(
    parameter int X0         = 64,
    parameter int X1         = 512,
    parameter int SCALE_LOG2 = 2
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [1:0]           wr_idx,
    input  logic [c_GLYPH_W-1:0] wr_data,
    input  logic                 clr,
    input  logic [9:0]           hpos,
    output logic                 pix
);

    localparam int c_CELL_W = c_GLYPH_W << SCALE_LOG2;
    localparam int c_PITCH  = c_CELL_PITCH << SCALE_LOG2;

    logic [c_GLYPH_W-1:0] r_buf [4];
    logic [3:0]           w_lit;
    logic [10:0]          w_hext;

    assign w_hext = {1'b0, hpos};

    // Row storage: cleared for lines outside the band, written during a fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_buf[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < 4; i++) r_buf[i] <= '0;
        end else if (wr_en) begin
            r_buf[wr_idx] <= wr_data;
        end
    end

    // Per-cell hit test and column lookup; bit 4 of a row is the leftmost pixel
    for (genvar k = 0; k < 4; k++) begin : g_cell
        localparam int          c_START = (k == 0) ? X0 :
                                          (k == 1) ? X0 + c_PITCH :
                                          (k == 2) ? X1 : X1 + c_PITCH;
        localparam logic [10:0] c_LO    = 11'(c_START);
        localparam logic [10:0] c_HI    = 11'(c_START + c_CELL_W);

        logic [10:0] w_off;
        logic [2:0]  w_col;
        logic        w_in;

        assign w_off    = w_hext - c_LO;
        assign w_in     = (w_hext >= c_LO) && (w_hext < c_HI);
        assign w_col    = 3'(w_off >> SCALE_LOG2);
        assign w_lit[k] = w_in && r_buf[k][3'd4 - w_col];
    end

    // Output pixel lags hpos by one clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pix <= 1'b0;
        else       pix <= |w_lit;
    end

endmodule
`default_nettype wire

// File: rtl/score_digit_seq.sv
`default_nettype none
// ============================================================================
// Module   : score_digit_seq
// Purpose  : Two-player score overlay. During hblank of the line before each
//            band line, fetches the four digit rows from an external 5x5 ROM
//            into a line buffer that is then scanned out as pix.
// Revision : 1.0 - initial release
// ============================================================================
module score_digit_seq
    import score_digit_seq_pkg::*;
#(
    parameter int X0         = 64,
    parameter int X1         = 512,
    parameter int Y0         = 16,
    parameter int SCALE_LOG2 = 2,
    parameter int FETCH_H    = 640,
    parameter int BLANK_LZ   = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        score_valid,
    input  logic [15:0] score_in,
    output logic        score_ready,
    output logic [3:0]  rom_digit,
    output logic [2:0]  rom_yofs,
    input  logic [4:0]  rom_bits,
    output logic        pix
);

    localparam logic [10:0] c_BAND_LO = 11'(Y0);
    localparam logic [10:0] c_BAND_HI = 11'(Y0 + (c_GLYPH_H << SCALE_LOG2));
    localparam logic [9:0]  c_FETCH_H = 10'(FETCH_H);

    state_t      r_state;
    logic [1:0]  r_k;
    logic [15:0] r_score;
    logic [11:0] r_snap;

    logic [10:0] w_vcur;
    logic [10:0] w_vnext;
    logic        w_cur_in;
    logic        w_next_in;
    logic [2:0]  w_row;
    logic        w_trig;
    logic        w_blank;
    logic        w_wr_en;
    logic        w_clr;
    logic [4:0]  w_wr_data;

    // Band membership of the current and the next scanline (11 bits, no wrap)
    assign w_vcur    = {1'b0, vpos};
    assign w_vnext   = w_vcur + 11'd1;
    assign w_cur_in  = (w_vcur  >= c_BAND_LO) && (w_vcur  < c_BAND_HI);
    assign w_next_in = (w_vnext >= c_BAND_LO) && (w_vnext < c_BAND_HI);
    assign w_row     = 3'((w_vnext - c_BAND_LO) >> SCALE_LOG2);

    assign w_trig      = (r_state == IDLE) && (hpos == c_FETCH_H);
    assign score_ready = (r_state == IDLE) && !w_cur_in;

    // Leading-zero blanking applies to the tens slots (even fetch index)
    assign w_blank   = (BLANK_LZ != 0) && !r_k[0] && (rom_digit == 4'd0);
    assign w_wr_data = w_blank ? 5'd0 : rom_bits;
    assign w_wr_en   = (r_state == FETCH);
    assign w_clr     = w_trig && !w_next_in;

    // Fetch sequencer: four consecutive ROM reads, ROM address held registered.
    // The lower three nibbles are snapshotted at trigger so a score accepted on
    // the trigger edge cannot mix into a fetch already under way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_k       <= 2'd0;
            r_snap    <= '0;
            rom_digit <= 4'd0;
            rom_yofs  <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trig && w_next_in) begin
                        r_state   <= FETCH;
                        r_k       <= 2'd0;
                        r_snap    <= r_score[11:0];
                        rom_digit <= score_nibble(r_score, 2'd0);
                        rom_yofs  <= w_row;
                    end
                end
                FETCH: begin
                    if (r_k == 2'd3) begin
                        r_state   <= IDLE;
                        r_k       <= 2'd0;
                        rom_digit <= 4'd0;
                        rom_yofs  <= 3'd0;
                    end else begin
                        r_k       <= r_k + 2'd1;
                        rom_digit <= score_nibble({4'h0, r_snap}, r_k + 2'd1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Score register: loads only while the band is not being drawn
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          r_score <= '0;
        else if (score_valid && score_ready) r_score <= score_in;
    end

    score_line_buf #(
        .X0         (X0),
        .X1         (X1),
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_line_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_en),
        .wr_idx  (r_k),
        .wr_data (w_wr_data),
        .clr     (w_clr),
        .hpos    (hpos),
        .pix     (pix)
    );

endmodule
`default_nettype wire

// File: tb/tb_score_digit_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_digit_seq
// Purpose  : Scoreboard bench for score_digit_seq with a 5x5 digit ROM model
//            and a frame-level reference model of the overlay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_digit_seq;

    localparam int X0      = 64;
    localparam int X1      = 512;
    localparam int Y0      = 16;
    localparam int SL      = 2;
    localparam int SC      = 1 << SL;
    localparam int BAND_H  = 5 * SC;
    localparam int FETCH_H = 640;
    localparam int LINE_W  = 648;
    localparam int N_LINES = 38;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic        score_valid;
    logic [15:0] score_in;
    logic        score_ready;
    logic [3:0]  rom_digit;
    logic [2:0]  rom_yofs;
    logic [4:0]  rom_bits;
    logic        pix;

    always #5 clk = ~clk;

    score_digit_seq #(
        .X0(X0), .X1(X1), .Y0(Y0), .SCALE_LOG2(SL), .FETCH_H(FETCH_H), .BLANK_LZ(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hpos        (hpos),
        .vpos        (vpos),
        .score_valid (score_valid),
        .score_in    (score_in),
        .score_ready (score_ready),
        .rom_digit   (rom_digit),
        .rom_yofs    (rom_yofs),
        .rom_bits    (rom_bits),
        .pix         (pix)
    );

    // External digit ROM: 0-9 real glyphs, 10-15 an arbitrary pattern
    function automatic logic [4:0] glyph(input int d, input int y);
        logic [24:0] f;
        if (y > 4) return 5'd0;
        case (d)
            0: f = 25'b11111_10001_10001_10001_11111;
            1: f = 25'b00100_01100_00100_00100_01110;
            2: f = 25'b11111_00001_11111_10000_11111;
            3: f = 25'b11111_00001_01111_00001_11111;
            4: f = 25'b10001_10001_11111_00001_00001;
            5: f = 25'b11111_10000_11111_00001_11111;
            6: f = 25'b11111_10000_11111_10001_11111;
            7: f = 25'b11111_00001_00010_00100_00100;
            8: f = 25'b11111_10001_11111_10001_11111;
            9: f = 25'b11111_10001_11111_00001_11111;
            default: return 5'((d * 7 + y * 3) & 31);
        endcase
        return f[24 - 5 * y -: 5];
    endfunction

    always_comb rom_bits = glyph(int'(rom_digit), int'(rom_yofs));

    // ---------------- reference model ----------------
    logic [4:0] m_rows [4];

    function automatic bit in_band(input int v);
        return (v >= Y0) && (v < Y0 + BAND_H);
    endfunction

    function automatic int nib(input logic [15:0] s, input int k);
        return int'((s >> (12 - 4 * k)) & 16'hF);
    endfunction

    function automatic logic [4:0] row_for(input logic [15:0] s, input int k, input int line);
        int d;
        d = nib(s, k);
        if ((k % 2 == 0) && d == 0) return 5'd0;
        return glyph(d, (line - Y0) / SC);
    endfunction

    function automatic int cell_start(input int k);
        case (k)
            0:       return X0;
            1:       return X0 + 6 * SC;
            2:       return X1;
            default: return X1 + 6 * SC;
        endcase
    endfunction

    function automatic logic exp_pix(input int h);
        int s;
        for (int k = 0; k < 4; k++) begin
            s = cell_start(k);
            if (h >= s && h < s + 5 * SC) return m_rows[k][4 - (h - s) / SC];
        end
        return 1'b0;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic       pix;
        logic [3:0] dig;
        logic [2:0] yofs;
        logic       rdy;
        int         v;
        int         h;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int expv, input int v, input int h);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s at v=%0d h=%0d: got %0d, expected %0d", name, v, h, act, expv);
        end
    endtask

    // Monitor: one expected record per clock, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("pix",         int'(pix),         int'(e.pix),  e.v, e.h);
                check("rom_digit",   int'(rom_digit),   int'(e.dig),  e.v, e.h);
                check("rom_yofs",    int'(rom_yofs),    int'(e.yofs), e.v, e.h);
                check("score_ready", int'(score_ready), int'(e.rdy),  e.v, e.h);
            end
        end
    end

    // Stimulus and model update
    initial begin
        logic [15:0] m_score;
        logic [15:0] f_score;
        logic [15:0] hold_word;
        bit          hold_active;
        bit          fetch_on;
        bit          do_rst;
        bit          in_win;
        int          prev_h;
        int          pulse_h;
        int          rst_line;
        exp_t        e;

        reset = 1'b1; hpos = '0; vpos = '0; score_valid = 1'b0; score_in = '0;
        m_score = '0; f_score = '0; hold_word = '0;
        hold_active = 1'b0; fetch_on = 1'b0; prev_h = -1;
        for (int k = 0; k < 4; k++) m_rows[k] = '0;
        rst_line = Y0 + int'($urandom_range(1, 17));

        repeat (3) @(negedge clk);
        check("reset_pix",       int'(pix),       0, -1, -1);
        check("reset_rom_digit", int'(rom_digit), 0, -1, -1);
        check("reset_rom_yofs",  int'(rom_yofs),  0, -1, -1);

        for (int fr = 0; fr < 3; fr++) begin
            for (int v = 0; v < N_LINES; v++) begin
                pulse_h = -1;
                if (fr > 0 && in_band(v) && $urandom_range(0, 2) == 0)
                    pulse_h = int'($urandom_range(0, 599));
                for (int h = 0; h < LINE_W; h++) begin
                    @(posedge clk); #1;
                    reset  = 1'b0;
                    do_rst = (fr == 2) && (v == rst_line) && (h == FETCH_H + 2);

                    if (fr == 0 && v == 0 && h == 10) begin
                        hold_active = 1'b1; hold_word = 16'h1234;
                    end
                    if (fr == 0 && v == Y0 + 2 && h == 100) begin
                        hold_active = 1'b1; hold_word = 16'h0809;
                    end
                    if (fr == 1 && v == Y0 + 5 && h == 200) begin
                        hold_active = 1'b1;
                        hold_word   = {4'($urandom), 4'h0, 8'($urandom)};
                    end

                    hpos = 10'(h);
                    vpos = 10'(v);
                    if (hold_active) begin
                        score_valid = 1'b1; score_in = hold_word;
                    end else if (h == pulse_h) begin
                        score_valid = 1'b1; score_in = 16'($urandom);
                    end else begin
                        score_valid = 1'b0;
                    end

                    if (do_rst) begin
                        reset    = 1'b1;
                        fetch_on = 1'b0;
                        m_score  = '0;
                        for (int k = 0; k < 4; k++) m_rows[k] = '0;
                    end

                    in_win = fetch_on && (h >= FETCH_H + 1) && (h <= FETCH_H + 4);
                    e.v    = v;
                    e.h    = h;
                    e.pix  = do_rst ? 1'b0 : exp_pix(prev_h);
                    e.dig  = in_win ? 4'(nib(f_score, h - FETCH_H - 1)) : 4'd0;
                    e.yofs = in_win ? 3'((v + 1 - Y0) / SC) : 3'd0;
                    e.rdy  = !in_band(v) && !in_win;
                    sbq.push_back(e);

                    // Effects of the clock edge closing this cycle
                    if (!do_rst) begin
                        if (h == FETCH_H + 4) fetch_on = 1'b0;
                        if (h == FETCH_H) begin
                            if (in_band(v + 1)) begin
                                fetch_on = 1'b1;
                                f_score  = m_score;
                                for (int k = 0; k < 4; k++) m_rows[k] = row_for(m_score, k, v + 1);
                            end else begin
                                for (int k = 0; k < 4; k++) m_rows[k] = '0;
                            end
                        end
                        if (score_valid && e.rdy) begin
                            m_score     = score_in;
                            hold_active = 1'b0;
                        end
                    end
                    prev_h = h;
                end
            end
        end

        @(posedge clk); #1;
        score_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("scoreboard_drain", sbq.size(), 0, -1, -1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Bound on total run time
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
